// File: rtl/frame_unpacker_pkg.sv
// Frame unpacker shared constants and state encoding.
// Also used by the pixel-readout FSM.
package frame_unpacker_pkg;

  localparam int NPIX_DEF = 512;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 6;
  localparam int DATA_W   = 6;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
  localparam int RAM_AW   = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ACCUM,
    DUMP
  } state_t;

endpackage

// File: rtl/pix_acc_ram.sv
// Per-pixel accumulator store: simple dual-port,
// one-cycle synchronous read, block-RAM style.
module pix_acc_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 16,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port plus registered read, no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_unpacker.sv
// Pulls pixel words from a FIFO, accumulates them
// over several frames, then streams the sums out.
module frame_unpacker
  import frame_unpacker_pkg::*;
#(
  parameter int NPIX  = NPIX_DEF,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       num_frames,
  input  logic [15:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_addr,
  output logic [ACC_W-1:0] out_data,
  output logic             frame_done,
  output logic             seq_err
);

  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(NPIX - 1);
  localparam logic [RAM_AW-1:0] LAST_P =
    RAM_AW'(NPIX - 1);
  localparam logic [ADDR_W:0] NPIX_L =
    (ADDR_W + 1)'(NPIX);

  state_t              state;
  logic [ADDR_W-1:0]   exp_addr;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic [7:0]          frame_idx;
  logic [7:0]          nf_r;
  logic [RAM_AW-1:0]   dptr;
  logic                dph;

  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                bad_addr;
  logic [7:0]          nf_eff;
  logic [8:0]          next_idx;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_wdata;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_raddr;
  logic [RAM_AW-1:0]   ram_waddr;
  logic [ACC_W-1:0]    ram_rdata;

  assign w_addr = fifo_dout[ADDR_MSB:ADDR_LSB];
  assign w_data = fifo_dout[DATA_W-1:0];
  assign bad_addr = w_addr[ADDR_W-1] ||
    ({1'b0, w_addr} >= NPIX_L);

  assign nf_eff = (nf_r == 8'd0) ? 8'd1 : nf_r;
  assign next_idx = {1'b0, frame_idx} + 9'd1;

  // saturating add, or overwrite on first frame
  always_comb begin
    sum = {1'b0, ram_rdata} +
      {{(ACC_W + 1 - DATA_W){1'b0}}, data_r};
    if (frame_idx == 8'd0) begin
      acc_wdata = {{(ACC_W - DATA_W){1'b0}}, data_r};
    end else if (sum[ACC_W]) begin
      acc_wdata = '1;
    end else begin
      acc_wdata = sum[ACC_W-1:0];
    end
  end

  assign fifo_rd_en = (state == FETCH) && en &&
    !fifo_empty;
  assign ram_we    = (state == ACCUM);
  assign ram_waddr = addr_r[RAM_AW-1:0];
  assign ram_raddr = (state == DUMP) ? dptr :
    w_addr[RAM_AW-1:0];

  pix_acc_ram #(
    .DEPTH (NPIX),
    .W     (ACC_W),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (acc_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // fetch/latch/accumulate loop and readout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      exp_addr   <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      frame_idx  <= '0;
      nf_r       <= '0;
      dptr       <= '0;
      dph        <= 1'b0;
      seq_err    <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          exp_addr  <= '0;
          frame_idx <= '0;
          if (en) begin
            nf_r  <= num_frames;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (!en) begin
            state <= IDLE;
          end else if (!fifo_empty) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          if (bad_addr) begin
            seq_err <= 1'b1;
            state   <= FETCH;
          end else begin
            if (w_addr != exp_addr) begin
              seq_err <= 1'b1;
            end
            addr_r <= w_addr;
            data_r <= w_data;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (addr_r == LAST_A) begin
            exp_addr  <= '0;
            frame_idx <= next_idx[7:0];
            if (next_idx >= {1'b0, nf_eff}) begin
              dptr  <= '0;
              dph   <= 1'b0;
              state <= DUMP;
            end else begin
              state <= FETCH;
            end
          end else begin
            exp_addr <= addr_r + 1'b1;
            state    <= FETCH;
          end
        end
        DUMP: begin
          if (out_valid) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (dptr == LAST_P) begin
                frame_done <= 1'b1;
                frame_idx  <= '0;
                nf_r       <= num_frames;
                state      <= en ? FETCH : IDLE;
              end else begin
                dptr <= dptr + 1'b1;
              end
            end
          end else if (dph) begin
            out_valid <= 1'b1;
            out_addr  <= dptr;
            out_data  <= ram_rdata;
            dph       <= 1'b0;
          end else begin
            dph <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_unpacker.sv
// Scoreboard bench for frame_unpacker, with a
// 16-bit and an 8-bit accumulator instance.
module tb_frame_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  num_frames = 8'd1;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        fifo_rd_en8;
  logic        out_ready = 1'b1;
  logic        out_valid, out_valid8;
  logic [8:0]  out_addr, out_addr8;
  logic [15:0] out_data;
  logic [7:0]  out_data8;
  logic        frame_done, frame_done8;
  logic        seq_err, seq_err8;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
    logic [7:0]  d8;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] fmem [16384];
  int          wp = 0;
  int          rp = 0;
  int          ncmp = 0;
  int          nerr = 0;
  int          beats = 0;
  int          fd_cnt = 0;
  bit          rdy_rand = 1'b0;
  bit          hold_v = 1'b0;
  logic [8:0]  hold_a;
  logic [15:0] hold_d;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en && (wp != rp)) begin
      fifo_dout <= fmem[rp];
      rp <= rp + 1;
    end
  end

  frame_unpacker #(.NPIX(512), .ACC_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .num_frames (num_frames),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .frame_done (frame_done),
    .seq_err    (seq_err)
  );

  frame_unpacker #(.NPIX(512), .ACC_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .num_frames (num_frames),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready),
    .out_addr   (out_addr8),
    .out_data   (out_data8),
    .frame_done (frame_done8),
    .seq_err    (seq_err8)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push_word(input int a, input int d);
    fmem[wp] = {10'(a), 6'(d)};
    wp++;
  endtask

  task automatic push_frame(input int mode,
                            input int dval,
                            input int skip,
                            input int bad_after);
    int d;
    for (int a = 0; a < 512; a++) begin
      if (a != skip) begin
        case (mode)
          0: d = a & 63;
          2: d = (a * 3) & 63;
          default: d = dval;
        endcase
        push_word(a, d);
      end
      if (a == bad_after) push_word(10'h3FF, 63);
    end
  endtask

  task automatic expect_px(input int a, input int d,
                           input int d8);
    exp_t e;
    e.a  = 9'(a);
    e.d  = 16'(d);
    e.d8 = 8'(d8);
    sbq.push_back(e);
  endtask

  task automatic wait_dump(input int fd_target);
    int n;
    n = 0;
    while (!out_valid && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("no_early_output",
        32'((n < 30000) && (rp == wp)), 1);
    n = 0;
    while (fd_cnt < fd_target && n < 30000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("frame_done_count", fd_cnt, fd_target);
    chk("scoreboard_drained", sbq.size(), 0);
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // monitor: pop and compare on every accepted beat
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hold_v && !rst) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, hold_a);
        chk("stall_data", out_data, hold_d);
      end
      if (out_valid && out_ready) begin
        beats++;
        if (sbq.size() == 0) begin
          chk("unexpected_beat", out_addr, 32'hFFFF);
        end else begin
          e = sbq.pop_front();
          chk("beat_addr", out_addr, e.a);
          chk("beat_data", out_data, e.d);
          chk("beat_addr8", out_addr8, e.a);
          chk("beat_data8", out_data8, e.d8);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_a = out_addr;
      hold_d = out_data;
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ?
        1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_valid8", out_valid8, 0);
    chk("rst_done8", frame_done8, 0);
    rst = 1'b0;
    @(negedge clk);

    num_frames = 8'd1;
    en = 1'b1;
    push_frame(0, 0, -1, -1);
    for (int a = 0; a < 512; a++)
      expect_px(a, a & 63, a & 63);
    wait_dump(1);
    chk("t1_seq_err", seq_err, 0);

    num_frames = 8'd3;
    en = 1'b1;
    repeat (3) push_frame(1, 63, -1, -1);
    for (int a = 0; a < 512; a++)
      expect_px(a, 189, 189);
    wait_dump(2);

    num_frames = 8'd5;
    en = 1'b1;
    repeat (5) push_frame(1, 63, -1, -1);
    for (int a = 0; a < 512; a++)
      expect_px(a, 315, 255);
    wait_dump(3);
    chk("t3_seq_err", seq_err, 0);
    chk("t3_seq_err8", seq_err8, 0);

    num_frames = 8'd2;
    en = 1'b1;
    push_frame(1, 1, -1, -1);
    push_frame(1, 2, 100, -1);
    for (int a = 0; a < 512; a++) begin
      if (a == 100) expect_px(a, 1, 1);
      else expect_px(a, 3, 3);
    end
    wait_dump(4);
    chk("t4_seq_err", seq_err, 1);
    chk("t4_seq_err8", seq_err8, 1);

    pulse_rst();
    chk("rst_clears_seq_err", seq_err, 0);
    num_frames = 8'd1;
    en = 1'b1;
    push_frame(1, 7, -1, 50);
    for (int a = 0; a < 512; a++)
      expect_px(a, 7, 7);
    wait_dump(5);
    chk("t5_seq_err", seq_err, 1);

    pulse_rst();
    num_frames = 8'd1;
    rdy_rand = 1'b1;
    en = 1'b1;
    push_frame(2, 0, -1, -1);
    for (int a = 0; a < 512; a++)
      expect_px(a, (a * 3) & 63, (a * 3) & 63);
    b0 = beats;
    n = 0;
    while (beats < b0 + 200 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_beat200", 32'(n < 30000), 1);
    #1;
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_addr", out_addr, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_done", frame_done, 0);
    chk("t6_rst_seq_err", seq_err, 0);
    chk("t6_rst_rd_en", fifo_rd_en, 0);
    chk("t6_rst_rd_en8", fifo_rd_en8, 0);
    sbq.delete();
    rdy_rand = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_word(0, 5);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (fifo_rd_en) seen = 1'b1;
    end
    chk("t6_no_read_without_en", 32'(seen), 0);
    en = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_rd_en) seen = 1'b1;
    end
    chk("t6_read_after_en", 32'(seen), 1);
    en = 1'b0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
